// File: rtl/burst_memory.sv
// burst_memory: byte-addressable RAM with a valid/ready request port, programmable
// access latency, flow-controlled write beats and big-endian byte/half/word/burst access.
// Requests with an unknown size, a misaligned address or an out-of-range span are
// rejected with a one-cycle err pulse and never touch the memory.
module burst_memory #(
    parameter int unsigned SIZE         = 4096,
    parameter logic [31:0] START_ADDR   = 32'h8002_0000,
    parameter int unsigned LATENCY      = 0,
    parameter              INITIAL_SNAP = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [31:0] beat_addr,
    output logic        busy,
    output logic        err
);

    localparam int          AW     = $clog2(SIZE);
    localparam logic [32:0] SIZE33 = 33'(SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_XFER = 2'b10
    } state_t;

    // Storage (not affected by reset)
    logic [7:0] mem [0:SIZE-1];

    // State and latched request
    state_t      state_r;
    state_t      state_next_s;
    logic        rw_r;
    logic [2:0]  size_r;
    logic [31:0] cur_off_r;
    logic [4:0]  beats_left_r;
    logic [3:0]  wait_cnt_r;

    // Registered outputs
    logic [31:0] rdata_r;
    logic        rdata_valid_r;
    logic [31:0] beat_addr_r;
    logic        err_r;
    logic        wready_r;

    // Request decode
    logic [31:0] req_off_s;
    logic [6:0]  req_bytes_s;
    logic [4:0]  req_beats_s;
    logic        size_bad_s;
    logic        align_bad_s;
    logic        range_bad_s;
    logic        reject_s;
    logic        accept_s;
    logic        accept_ok_s;

    // Beat sequencing
    logic        load_s;
    logic [31:0] load_off_s;
    logic        cur_rw_s;
    logic [2:0]  cur_size_s;
    logic        beat_done_s;
    logic [31:0] rd_word_s;

    // Write lanes, index i = byte offset i within the addressed word
    logic [3:0]  we_s;
    logic [7:0]  wd_s [0:3];

    // Select the byte/half/word from a big-endian memory word and zero-extend
    function automatic logic [31:0] fmt_rdata(input logic [31:0] word,
                                              input logic [1:0]  lo,
                                              input logic [2:0]  size);
        logic [31:0] res;
        case (size)
            3'b100: begin
                case (lo)
                    2'b00:   res = {24'h000000, word[31:24]};
                    2'b01:   res = {24'h000000, word[23:16]};
                    2'b10:   res = {24'h000000, word[15:8]};
                    default: res = {24'h000000, word[7:0]};
                endcase
            end
            3'b101:  res = lo[1] ? {16'h0000, word[15:0]} : {16'h0000, word[31:16]};
            default: res = word;
        endcase
        return res;
    endfunction

    assign req_off_s   = req_addr - START_ADDR;
    assign accept_s    = req_valid && (state_r == ST_IDLE);
    assign accept_ok_s = accept_s && !reject_s;
    assign cur_rw_s    = (state_r == ST_IDLE) ? req_rw : rw_r;
    assign cur_size_s  = (state_r == ST_IDLE) ? req_size : size_r;
    assign beat_done_s = rw_r ? (wvalid && wready_r) : 1'b1;

    // Decode size into span/beat count and classify rejections (no address wrap-around)
    always_comb begin
        req_bytes_s = 7'd4;
        req_beats_s = 5'd1;
        size_bad_s  = 1'b0;
        align_bad_s = 1'b0;
        case (req_size)
            3'b000: begin req_bytes_s = 7'd4;  req_beats_s = 5'd1;  align_bad_s = (req_addr[1:0] != 2'b00); end
            3'b001: begin req_bytes_s = 7'd16; req_beats_s = 5'd4;  align_bad_s = (req_addr[1:0] != 2'b00); end
            3'b010: begin req_bytes_s = 7'd32; req_beats_s = 5'd8;  align_bad_s = (req_addr[1:0] != 2'b00); end
            3'b011: begin req_bytes_s = 7'd64; req_beats_s = 5'd16; align_bad_s = (req_addr[1:0] != 2'b00); end
            3'b100: begin req_bytes_s = 7'd1;  req_beats_s = 5'd1;  align_bad_s = 1'b0; end
            3'b101: begin req_bytes_s = 7'd2;  req_beats_s = 5'd1;  align_bad_s = req_addr[0]; end
            default: begin req_bytes_s = 7'd1; req_beats_s = 5'd1;  size_bad_s = 1'b1; end
        endcase
        range_bad_s = (req_addr < START_ADDR) ||
                      (({1'b0, req_off_s} + {26'd0, req_bytes_s}) > SIZE33);
        reject_s    = size_bad_s || align_bad_s || range_bad_s;
    end

    // Next state and beat-load control; a load presents the next beat in the following cycle
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        load_off_s   = cur_off_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_ok_s) begin
                    load_off_s = req_off_s;
                    if (LATENCY == 0) begin
                        state_next_s = ST_XFER;
                        load_s       = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_next_s = ST_XFER;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_XFER: begin
                if (beat_done_s) begin
                    if (beats_left_r == 5'd1) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        load_s     = 1'b1;
                        load_off_s = cur_off_r + 32'd4;
                    end
                end else begin
                    state_next_s = ST_XFER;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Read the aligned word containing the beat being loaded
    always_comb begin
        rd_word_s = {mem[{load_off_s[AW-1:2], 2'b00}], mem[{load_off_s[AW-1:2], 2'b01}],
                     mem[{load_off_s[AW-1:2], 2'b10}], mem[{load_off_s[AW-1:2], 2'b11}]};
    end

    // Byte-lane enables and data for the write beat accepted this cycle
    always_comb begin
        we_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wd_s[i] = wdata[7:0];
        end
        if ((state_r == ST_XFER) && rw_r && wvalid && wready_r) begin
            case (size_r)
                3'b100: begin
                    we_s = 4'b0001 << cur_off_r[1:0];
                end
                3'b101: begin
                    we_s    = cur_off_r[1] ? 4'b1100 : 4'b0011;
                    wd_s[0] = wdata[15:8];
                    wd_s[1] = wdata[7:0];
                    wd_s[2] = wdata[15:8];
                    wd_s[3] = wdata[7:0];
                end
                default: begin
                    we_s    = 4'b1111;
                    wd_s[0] = wdata[31:24];
                    wd_s[1] = wdata[23:16];
                    wd_s[2] = wdata[15:8];
                    wd_s[3] = wdata[7:0];
                end
            endcase
        end else begin
            we_s = 4'b0000;
        end
    end

    // Memory write port
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_s[i]) begin
                mem[{cur_off_r[AW-1:2], 2'(i)}] <= wd_s[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latched request fields, beat pointer and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_r         <= 1'b0;
            size_r       <= 3'b000;
            cur_off_r    <= 32'd0;
            beats_left_r <= 5'd0;
            wait_cnt_r   <= 4'd0;
        end else if (accept_ok_s) begin
            rw_r         <= req_rw;
            size_r       <= req_size;
            cur_off_r    <= req_off_s;
            beats_left_r <= req_beats_s;
            wait_cnt_r   <= 4'(LATENCY - 32'd1);
        end else begin
            if (load_s) begin
                cur_off_r <= load_off_s;
            end
            if (load_s && (state_r == ST_XFER)) begin
                beats_left_r <= beats_left_r - 5'd1;
            end
            if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end
        end
    end

    // Registered outputs: beat data/address, write-ready and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r       <= 32'd0;
            rdata_valid_r <= 1'b0;
            beat_addr_r   <= 32'd0;
            err_r         <= 1'b0;
            wready_r      <= 1'b0;
        end else begin
            err_r         <= accept_s && reject_s;
            wready_r      <= (state_next_s == ST_XFER) && cur_rw_s;
            rdata_valid_r <= load_s && !cur_rw_s;
            if (load_s) begin
                beat_addr_r <= load_off_s + START_ADDR;
            end
            if (load_s && !cur_rw_s) begin
                rdata_r <= fmt_rdata(rd_word_s, load_off_s[1:0], cur_size_s);
            end
        end
    end

    assign req_ready   = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign wready      = wready_r;
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign beat_addr   = beat_addr_r;
    assign err         = err_r;

endmodule

// File: tb/tb_burst_memory.sv
// Directed, self-checking bench for burst_memory: two instances (latency 0 and 3),
// a byte-level reference model and a queue of expected read beats.
module tb_burst_memory;

    localparam int          SZ = 4096;
    localparam logic [31:0] ST = 32'h8002_0000;

    logic clk;
    logic rst_n;

    logic        req_valid_a   [0:1];
    logic        req_ready_a   [0:1];
    logic        req_rw_a      [0:1];
    logic [31:0] req_addr_a    [0:1];
    logic [2:0]  req_size_a    [0:1];
    logic [31:0] wdata_a       [0:1];
    logic        wvalid_a      [0:1];
    logic        wready_a      [0:1];
    logic [31:0] rdata_a       [0:1];
    logic        rdata_valid_a [0:1];
    logic [31:0] beat_addr_a   [0:1];
    logic        busy_a        [0:1];
    logic        err_a         [0:1];

    burst_memory #(.SIZE(SZ), .START_ADDR(ST), .LATENCY(0), .INITIAL_SNAP("")) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_rw(req_rw_a[0]),
        .req_addr(req_addr_a[0]), .req_size(req_size_a[0]), .wdata(wdata_a[0]),
        .wvalid(wvalid_a[0]), .wready(wready_a[0]), .rdata(rdata_a[0]),
        .rdata_valid(rdata_valid_a[0]), .beat_addr(beat_addr_a[0]), .busy(busy_a[0]),
        .err(err_a[0])
    );

    burst_memory #(.SIZE(SZ), .START_ADDR(ST), .LATENCY(3), .INITIAL_SNAP("")) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_rw(req_rw_a[1]),
        .req_addr(req_addr_a[1]), .req_size(req_size_a[1]), .wdata(wdata_a[1]),
        .wvalid(wvalid_a[1]), .wready(wready_a[1]), .rdata(rdata_a[1]),
        .rdata_valid(rdata_valid_a[1]), .beat_addr(beat_addr_a[1]), .busy(busy_a[1]),
        .err(err_a[1])
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q [$];
    logic [7:0]  model [0:1][0:SZ-1];
    logic [31:0] wbuf  [0:15];
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int beats_of(input logic [2:0] size);
        case (size)
            3'b001:  return 4;
            3'b010:  return 8;
            3'b011:  return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int d, input int o, input logic [2:0] size);
        case (size)
            3'b100:  return {24'h000000, model[d][o]};
            3'b101:  return {16'h0000, model[d][o], model[d][o+1]};
            default: return {model[d][o], model[d][o+1], model[d][o+2], model[d][o+3]};
        endcase
    endfunction

    task automatic model_write(input int d, input int o, input logic [2:0] size, input logic [31:0] v);
        case (size)
            3'b100: model[d][o] = v[7:0];
            3'b101: begin
                model[d][o]   = v[15:8];
                model[d][o+1] = v[7:0];
            end
            default: begin
                model[d][o]   = v[31:24];
                model[d][o+1] = v[23:16];
                model[d][o+2] = v[15:8];
                model[d][o+3] = v[7:0];
            end
        endcase
    endtask

    // Read request: expected beats go on the queue, then are popped as the DUT returns them
    task automatic do_read(input int d, input logic [31:0] addr, input logic [2:0] size);
        int    nb;
        int    o;
        int    lat;
        int    cyc;
        bit    started;
        beat_t b;
        nb  = beats_of(size);
        o   = int'(addr - ST);
        lat = (d == 0) ? 0 : 3;
        chk("rd_req_ready", {31'd0, req_ready_a[d]}, 32'd1);
        req_valid_a[d] = 1'b1;
        req_rw_a[d]    = 1'b0;
        req_addr_a[d]  = addr;
        req_size_a[d]  = size;
        step();
        req_valid_a[d] = 1'b0;
        chk("rd_busy", {31'd0, busy_a[d]}, 32'd1);
        for (int k = 0; k < nb; k++) begin
            exp_q.push_back('{addr: addr + 32'(4 * k), data: model_read(d, o + 4 * k, size)});
        end
        cyc     = 0;
        started = 1'b0;
        while (exp_q.size() > 0 && cyc < 64) begin
            if (rdata_valid_a[d]) begin
                if (!started) begin
                    chk("rd_first_latency", 32'(cyc), 32'(lat));
                end
                started = 1'b1;
                b = exp_q.pop_front();
                chk("rd_data", rdata_a[d], b.data);
                chk("rd_beat_addr", beat_addr_a[d], b.addr);
                chk("rd_req_ready_low", {31'd0, req_ready_a[d]}, 32'd0);
            end else if (started) begin
                chk("rd_beat_gap", {31'd0, rdata_valid_a[d]}, 32'd1);
            end
            step();
            cyc++;
        end
        chk("rd_timeout_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("rd_done_ready", {31'd0, req_ready_a[d]}, 32'd1);
        chk("rd_done_valid", {31'd0, rdata_valid_a[d]}, 32'd0);
    endtask

    // Write request from wbuf; optional stall before one beat; optional abort at a beat
    task automatic do_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                            input int stall_beat, input int stall_cyc, input int abort_beat);
        int nb;
        int o;
        int n;
        nb = beats_of(size);
        o  = int'(addr - ST);
        req_valid_a[d] = 1'b1;
        req_rw_a[d]    = 1'b1;
        req_addr_a[d]  = addr;
        req_size_a[d]  = size;
        wvalid_a[d]    = 1'b0;
        step();
        req_valid_a[d] = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (k == abort_beat) begin
                wvalid_a[d] = 1'b0;
                return;
            end
            if (k == stall_beat) begin
                wvalid_a[d] = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    step();
                    chk("wr_stall_wready", {31'd0, wready_a[d]}, 32'd1);
                    chk("wr_stall_busy", {31'd0, busy_a[d]}, 32'd1);
                    chk("wr_stall_addr", beat_addr_a[d], addr + 32'(4 * k));
                end
            end
            wvalid_a[d] = 1'b1;
            wdata_a[d]  = wbuf[k];
            n = 0;
            while (!wready_a[d] && n < 20) begin
                step();
                n++;
            end
            chk("wr_wready", {31'd0, wready_a[d]}, 32'd1);
            chk("wr_beat_addr", beat_addr_a[d], addr + 32'(4 * k));
            chk("wr_no_rvalid", {31'd0, rdata_valid_a[d]}, 32'd0);
            step();
            model_write(d, o + 4 * k, size, wbuf[k]);
        end
        wvalid_a[d] = 1'b0;
        chk("wr_done_idle", {31'd0, busy_a[d]}, 32'd0);
        chk("wr_done_wready", {31'd0, wready_a[d]}, 32'd0);
    endtask

    // Request that must be refused with a single err pulse and no state change
    task automatic do_reject(input int d, input logic [31:0] addr, input logic [2:0] size, input logic rw);
        req_valid_a[d] = 1'b1;
        req_rw_a[d]    = rw;
        req_addr_a[d]  = addr;
        req_size_a[d]  = size;
        wvalid_a[d]    = rw;
        wdata_a[d]     = 32'hDEAD_BEEF;
        step();
        req_valid_a[d] = 1'b0;
        chk("rej_err", {31'd0, err_a[d]}, 32'd1);
        chk("rej_busy", {31'd0, busy_a[d]}, 32'd0);
        chk("rej_ready", {31'd0, req_ready_a[d]}, 32'd1);
        chk("rej_wready", {31'd0, wready_a[d]}, 32'd0);
        step();
        wvalid_a[d] = 1'b0;
        chk("rej_err_pulse", {31'd0, err_a[d]}, 32'd0);
        chk("rej_rvalid", {31'd0, rdata_valid_a[d]}, 32'd0);
    endtask

    task automatic check_reset_outputs(input int d);
        chk("rst_rdata", rdata_a[d], 32'd0);
        chk("rst_rvalid", {31'd0, rdata_valid_a[d]}, 32'd0);
        chk("rst_beat_addr", beat_addr_a[d], 32'd0);
        chk("rst_err", {31'd0, err_a[d]}, 32'd0);
        chk("rst_wready", {31'd0, wready_a[d]}, 32'd0);
        chk("rst_busy", {31'd0, busy_a[d]}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_a[d]}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid_a[d] = 1'b0;
            req_rw_a[d]    = 1'b0;
            req_addr_a[d]  = 32'd0;
            req_size_a[d]  = 3'b000;
            wdata_a[d]     = 32'd0;
            wvalid_a[d]    = 1'b0;
        end

        // Reset state
        step();
        step();
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst_n = 1'b1;
        step();

        // Image 11 22 33 44 at byte 0, single word read with zero latency
        wbuf[0] = 32'h1122_3344;
        do_write(0, ST, 3'b000, -1, 0, -1);
        do_read(0, ST, 3'b000);

        // Latency 3: 8-word burst written then read back
        for (int k = 0; k < 16; k++) wbuf[k] = 32'hC0DE_0000 + 32'(k * 32'h0101);
        do_write(1, ST + 32'h10, 3'b010, -1, 0, -1);
        do_read(1, ST + 32'h10, 3'b010);

        // 4-word burst write stalled on beat 1 for 5 cycles, neighbours untouched
        wbuf[0] = 32'hAAAA_0001;
        do_write(0, ST + 32'h40, 3'b000, -1, 0, -1);
        wbuf[0] = 32'hBBBB_0002;
        do_write(0, ST + 32'h54, 3'b000, -1, 0, -1);
        for (int k = 0; k < 4; k++) wbuf[k] = 32'h5000_0000 + 32'(k * 32'h1111_1111);
        do_write(0, ST + 32'h44, 3'b001, 1, 5, -1);
        do_read(0, ST + 32'h44, 3'b001);
        do_read(0, ST + 32'h40, 3'b000);
        do_read(0, ST + 32'h54, 3'b000);
        do_read(0, ST + 32'h40, 3'b010 - 3'b001);

        // Byte and half writes inside a word
        wbuf[0] = 32'h0102_0304;
        do_write(0, ST + 32'h4, 3'b000, -1, 0, -1);
        wbuf[0] = 32'h0000_00AB;
        do_write(0, ST + 32'h5, 3'b100, -1, 0, -1);
        wbuf[0] = 32'h0000_CDEF;
        do_write(0, ST + 32'h6, 3'b101, -1, 0, -1);
        do_read(0, ST + 32'h4, 3'b000);
        chk("t4_word_literal", model_read(0, 4, 3'b000), 32'h01AB_CDEF);
        do_read(0, ST + 32'h5, 3'b100);
        do_read(0, ST + 32'h6, 3'b101);
        do_read(0, ST + 32'h4, 3'b101);

        // Rejections, then memory proven unmodified
        do_reject(0, ST + 32'h1, 3'b101, 1'b1);
        do_reject(0, ST + 32'h2, 3'b000, 1'b1);
        do_reject(0, ST + 32'(SZ - 32), 3'b011, 1'b0);
        do_reject(0, ST, 3'b111, 1'b1);
        do_reject(0, 32'h8001_FFFC, 3'b000, 1'b1);
        do_reject(0, 32'hFFFF_FFFC, 3'b000, 1'b0);
        do_reject(1, ST + 32'h3, 3'b001, 1'b0);
        do_read(0, ST, 3'b000);
        do_read(0, ST + 32'h4, 3'b000);

        // End-of-memory boundary: last byte and a 16-word burst ending exactly at SIZE
        wbuf[0] = 32'h0000_005A;
        do_write(0, ST + 32'(SZ - 1), 3'b100, -1, 0, -1);
        do_read(0, ST + 32'(SZ - 1), 3'b100);
        for (int k = 0; k < 16; k++) wbuf[k] = 32'hE000_0000 + 32'(k);
        do_write(0, ST + 32'(SZ - 64), 3'b011, -1, 0, -1);
        do_read(0, ST + 32'(SZ - 64), 3'b011);

        // Reset during beat 3 of a 16-word write
        for (int k = 0; k < 16; k++) wbuf[k] = 32'hA5A5_0000 + 32'(k);
        do_write(0, ST + 32'h100, 3'b011, -1, 0, -1);
        for (int k = 0; k < 16; k++) wbuf[k] = 32'h3C3C_0000 + 32'(k);
        do_write(0, ST + 32'h100, 3'b011, -1, 0, 3);
        chk("abort_in_xfer", {31'd0, busy_a[0]}, 32'd1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs(0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("abort_beat0_model", model_read(0, 32'h100, 3'b000), 32'h3C3C_0000);
        chk("abort_beat3_model", model_read(0, 32'h10C, 3'b000), 32'hA5A5_0003);
        do_read(0, ST + 32'h100, 3'b011);
        do_read(1, ST + 32'h10, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
